// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and
// the default operand width.
package seq_divider32_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider32_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference
// only when it does not borrow. The shifted value is WIDTH+1 bits so the
// bit pushed out of the remainder MSB still takes part in the compare.
module seq_divider32_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // shift, trial subtract and restore when the subtraction borrows
    always_comb begin
        shifted_s = {rem, q_msb};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_next = diff_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider32.sv
// Iterative restoring divider, one quotient bit per clock.
// Optional build macro: DIVIDER_SIGNED_EN selects two's-complement operands
// (magnitudes are divided, a FIXUP cycle restores the signs). Without it the
// divider is unsigned only and no negation logic is built.
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       state_r;
    div_state_t       state_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             start_ok_s;
    logic             div_zero_s;
    logic             last_iter_s;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_step_s;
    logic             q_bit_s;
    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;

    // two's-complement negate when en is set
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        if (en) begin
            neg_if = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            neg_if = v;
        end
    endfunction

    assign dividend_mag_s = neg_if(dividend, dividend[WIDTH-1]);
    assign divisor_mag_s  = neg_if(divisor, divisor[WIDTH-1]);
`else
    assign dividend_mag_s = dividend;
    assign divisor_mag_s  = divisor;
`endif

    assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign div_zero_s  = (divisor == {WIDTH{1'b0}});
    assign last_iter_s = (count_r == CNT_ONE);

    seq_divider32_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .q_msb    (q_r[WIDTH-1]),
        .divisor  (divisor_r),
        .rem_next (rem_step_s),
        .q_bit    (q_bit_s)
    );

    // state register plus registered busy/done status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= busy_nxt_s;
            done    <= done_nxt_s;
        end
    end

    // next-state decode; IDLE and DONE both accept a new start
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = div_zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter_s) begin
`ifdef DIVIDER_SIGNED_EN
                    state_nxt_s = ST_FIXUP;
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
`ifdef DIVIDER_SIGNED_EN
            ST_FIXUP: begin
                state_nxt_s = ST_DONE;
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // status outputs for the upcoming state, registered above
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RUN, ST_FIXUP: busy_nxt_s = 1'b1;
            ST_DONE:          done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r     <= {CNT_W{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else if (start_ok_s) begin
            count_r   <= CNT_LOAD;
            q_r       <= dividend_mag_s;
            rem_r     <= {WIDTH{1'b0}};
            divisor_r <= divisor_mag_s;
`ifdef DIVIDER_SIGNED_EN
            neg_q_r   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_r   <= dividend[WIDTH-1];
`endif
            if (div_zero_s) begin
                // divide-by-zero goes straight to DONE with fixed results
                quotient    <= {WIDTH{1'b1}};
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= {WIDTH{1'b0}};
                remainder   <= {WIDTH{1'b0}};
                div_by_zero <= 1'b0;
            end
        end else if (state_r == ST_RUN) begin
            q_r     <= {q_r[WIDTH-2:0], q_bit_s};
            rem_r   <= rem_step_s;
            count_r <= count_r - CNT_ONE;
`ifndef DIVIDER_SIGNED_EN
            if (last_iter_s) begin
                quotient  <= {q_r[WIDTH-2:0], q_bit_s};
                remainder <= rem_step_s;
            end else begin
                quotient  <= quotient;
                remainder <= remainder;
            end
`endif
`ifdef DIVIDER_SIGNED_EN
        end else if (state_r == ST_FIXUP) begin
            // quotient truncates toward zero, remainder follows the dividend sign
            quotient  <= neg_if(q_r, neg_q_r);
            remainder <= neg_if(rem_r, neg_r_r);
`endif
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: latency, results, /0, ignored start,
// reset abort, back-to-back restart, signed cases and a random sweep.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int busy_cnt;
    int n_done;

`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    always #5 clk = ~clk;

    seq_divider32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // start cycle is cycle 0; returns with cyc = 1
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
        cyc      = 1;
        busy_cnt = 0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eq;
        logic [31:0] er;
        logic signed [31:0] sa;
        logic signed [31:0] sb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 100 / 7
        launch(32'd100, 32'd7);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        wait_done();
        check("t1_latency", cyc, LAT);
        check("t1_busy_cycles", busy_cnt, LAT - 1);
        check("t1_quot", quotient, 32'd14);
        check("t1_rem", remainder, 32'd2);
        check("t1_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_quot_hold", quotient, 32'd14);

        // 0xFFFFFFFF / 1
        launch(32'hFFFF_FFFF, 32'd1);
        wait_done();
        check("t2a_latency", cyc, LAT);
        check("t2a_quot", quotient, 32'hFFFF_FFFF);
        check("t2a_rem", remainder, 32'd0);
        tick();

        // 5 / 0
        launch(32'd5, 32'd0);
        wait_done();
        check("t2b_latency", cyc, 1);
        check("t2b_quot", quotient, 32'hFFFF_FFFF);
        check("t2b_rem", remainder, 32'd5);
        check("t2b_dbz", {31'd0, div_by_zero}, 32'd1);
        tick();

        // start during RUN is ignored
        launch(32'd200, 32'd7);
        tick(); tick(); tick();
        cyc      = 4;
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        wait_done();
        check("t3_latency", cyc, LAT);
        check("t3_quot", quotient, 32'd28);
        check("t3_rem", remainder, 32'd4);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("t3_extra_done", n_done, 0);
        check("t3_quot_hold", quotient, 32'd28);

        // reset in the middle of a division
        launch(32'd1000, 32'd3);
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_quot", quotient, 32'd0);
        check("t4_rem", remainder, 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("t4_no_done", n_done, 0);
        launch(32'd9, 32'd3);
        wait_done();
        check("t4_quot_9_3", quotient, 32'd3);
        check("t4_rem_9_3", remainder, 32'd0);
        tick();

        // back-to-back restart from the DONE cycle
        launch(32'd17, 32'd4);
        wait_done();
        check("t5_first_quot", quotient, 32'd4);
        check("t5_first_rem", remainder, 32'd1);
        launch(32'd1000, 32'd10);
        check("t5_cleared", quotient, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        wait_done();
        check("t5_latency", cyc, LAT);
        check("t5_quot", quotient, 32'd100);
        check("t5_rem", remainder, 32'd0);
        tick();

        // -7 / 2 and MIN / -1
        launch(32'hFFFF_FFF9, 32'd2);
        wait_done();
        check("t6_latency", cyc, LAT);
`ifdef DIVIDER_SIGNED_EN
        check("t6_quot", quotient, 32'hFFFF_FFFD);
        check("t6_rem", remainder, 32'hFFFF_FFFF);
`else
        check("t6_quot", quotient, 32'h7FFF_FFFC);
        check("t6_rem", remainder, 32'd1);
`endif
        tick();
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
`ifdef DIVIDER_SIGNED_EN
        check("t6_min_quot", quotient, 32'h8000_0000);
        check("t6_min_rem", remainder, 32'd0);
`else
        check("t6_min_quot", quotient, 32'd0);
        check("t6_min_rem", remainder, 32'h8000_0000);
`endif
        check("t6_min_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();

        // random operands against the language's own division
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd1;
`ifdef DIVIDER_SIGNED_EN
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            sa = ra;
            sb = rb;
            eq = sa / sb;
            er = sa % sb;
`else
            eq = ra / rb;
            er = ra % rb;
`endif
            launch(ra, rb);
            wait_done();
            check("rnd_quot", quotient, eq);
            check("rnd_rem", remainder, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
